// File: rtl/mux4x1_pkg.sv
// Shared select type and constants for the mux4x1 data selector.
package mux4x1_pkg;

  typedef logic [1:0] sel_t;

  localparam sel_t SEL_I0 = 2'b00;
  localparam sel_t SEL_I1 = 2'b01;
  localparam sel_t SEL_I2 = 2'b10;
  localparam sel_t SEL_I3 = 2'b11;

  localparam logic [3:0] SEL_OH_RST = 4'b0001;

endpackage

// File: rtl/mux4x1_if.sv
// Bus bundle for mux4x1: enable, four sources, select pair, selected data and one-hot source flag.
interface mux4x1_if #(
  parameter int WIDTH = 1
);
  logic             en_311;
  logic [WIDTH-1:0] i0_311;
  logic [WIDTH-1:0] i1_311;
  logic [WIDTH-1:0] i2_311;
  logic [WIDTH-1:0] i3_311;
  logic             s0_311;
  logic             s1_311;
  logic [WIDTH-1:0] y_311;
  logic [3:0]       sel_oh_311;

  modport master (
    output en_311, i0_311, i1_311, i2_311, i3_311, s0_311, s1_311,
    input  y_311, sel_oh_311
  );

  modport slave (
    input  en_311, i0_311, i1_311, i2_311, i3_311, s0_311, s1_311,
    output y_311, sel_oh_311
  );
endinterface

// File: rtl/mux4x1_sel_decode.sv
// 2-to-4 one-hot select decoder; an unknown select yields no active source.
module mux4x1_sel_decode
  import mux4x1_pkg::*;
(
  input  sel_t       sel_i,
  output logic [3:0] oh_o
);

  always_comb begin
    oh_o = 4'b0000;
    if (!$isunknown(sel_i)) begin
      case (sel_i)
        SEL_I0:  oh_o = 4'b0001;
        SEL_I1:  oh_o = 4'b0010;
        SEL_I2:  oh_o = 4'b0100;
        SEL_I3:  oh_o = 4'b1000;
        default: oh_o = 4'b0000;
      endcase
    end
  end

endmodule

// File: rtl/mux4x1.sv
// 4-to-1 data selector with one-hot source indication.
// MUX4X1_OUT_REG_EN defined: registered outputs (1-cycle latency, en_311 hold); otherwise combinational.
module mux4x1
  import mux4x1_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic           clk_311,
  input  logic           rst_n_311,
  mux4x1_if.slave        bus
);

  sel_t             sel;
  logic [3:0]       oh_d;
  logic [WIDTH-1:0] y_d;

  assign sel = {bus.s1_311, bus.s0_311};

  mux4x1_sel_decode u_dec (
    .sel_i (sel),
    .oh_o  (oh_d)
  );

  // AND-OR steering: an all-zero one-hot (unknown select) forces zero data.
  assign y_d = ({WIDTH{oh_d[0]}} & bus.i0_311)
             | ({WIDTH{oh_d[1]}} & bus.i1_311)
             | ({WIDTH{oh_d[2]}} & bus.i2_311)
             | ({WIDTH{oh_d[3]}} & bus.i3_311);

`ifdef MUX4X1_OUT_REG_EN
  logic [WIDTH-1:0] y_q;
  logic [3:0]       oh_q;

  always_ff @(posedge clk_311) begin
    if (!rst_n_311) begin
      y_q  <= '0;
      oh_q <= SEL_OH_RST;
    end else if (bus.en_311) begin
      y_q  <= y_d;
      oh_q <= oh_d;
    end
  end

  assign bus.y_311      = y_q;
  assign bus.sel_oh_311 = oh_q;
`else
  // Clock and enable have no role without the output register.
  logic unused_ok;
  assign unused_ok = ^{clk_311, bus.en_311};

  assign bus.y_311      = rst_n_311 ? y_d  : '0;
  assign bus.sel_oh_311 = rst_n_311 ? oh_d : SEL_OH_RST;
`endif

endmodule

// File: tb/tb_mux4x1.sv
// Directed bench for mux4x1 at WIDTH 1 and 8; covers registered and combinational builds.
module tb_mux4x1;

  logic clk_311 = 1'b0;
  logic rst_n_311;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk_311 = ~clk_311;

  mux4x1_if #(.WIDTH(1)) if1 ();
  mux4x1_if #(.WIDTH(8)) if8 ();

  mux4x1 #(.WIDTH(1)) u_dut1 (.clk_311(clk_311), .rst_n_311(rst_n_311), .bus(if1));
  mux4x1 #(.WIDTH(8)) u_dut8 (.clk_311(clk_311), .rst_n_311(rst_n_311), .bus(if8));

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
`ifdef MUX4X1_OUT_REG_EN
    @(posedge clk_311);
    #1;
`else
    #1;
`endif
  endtask

  initial begin
    logic       exp_y1 [4];
    logic [3:0] exp_oh [4];
    exp_y1 = '{1'b1, 1'b0, 1'b1, 1'b0};
    exp_oh = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

    // Reset with arbitrary inputs
    rst_n_311 = 1'b0;
    if1.en_311 = 1'b1; if1.i0_311 = 1'b0; if1.i1_311 = 1'b1;
    if1.i2_311 = 1'b1; if1.i3_311 = 1'b1; {if1.s1_311, if1.s0_311} = 2'b11;
    if8.en_311 = 1'b1; if8.i0_311 = 8'h11; if8.i1_311 = 8'h22;
    if8.i2_311 = 8'h5A; if8.i3_311 = 8'hFF; {if8.s1_311, if8.s0_311} = 2'b10;
    step();
    step();
    check("rst_y1",  8'(if1.y_311), 8'h00);
    check("rst_oh1", 8'(if1.sel_oh_311), 8'h01);
    check("rst_y8",  if8.y_311, 8'h00);
    check("rst_oh8", 8'(if8.sel_oh_311), 8'h01);

    // Select sweep at WIDTH 1
    rst_n_311 = 1'b1;
    if1.i0_311 = 1'b1; if1.i1_311 = 1'b0; if1.i2_311 = 1'b1; if1.i3_311 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      {if1.s1_311, if1.s0_311} = 2'(k);
      step();
      check($sformatf("sweep_y_%0d", k),  8'(if1.y_311), 8'(exp_y1[k]));
      check($sformatf("sweep_oh_%0d", k), 8'(if1.sel_oh_311), 8'(exp_oh[k]));
    end

`ifdef MUX4X1_OUT_REG_EN
    // Hold: enable low ignores select and data changes
    {if1.s1_311, if1.s0_311} = 2'b00;
    step();
    check("hold_pre_y", 8'(if1.y_311), 8'h01);
    if1.en_311 = 1'b0;
    {if1.s1_311, if1.s0_311} = 2'b01;
    if1.i0_311 = 1'b0;
    step();
    check("hold_y",  8'(if1.y_311), 8'h01);
    check("hold_oh", 8'(if1.sel_oh_311), 8'h01);
    step();
    check("hold_y2", 8'(if1.y_311), 8'h01);
`else
    // Enable has no effect: outputs follow the select immediately
    if1.en_311 = 1'b0;
    {if1.s1_311, if1.s0_311} = 2'b01;
    #1;
    check("noen_y",  8'(if1.y_311), 8'h00);
    check("noen_oh", 8'(if1.sel_oh_311), 8'h02);
    // Select 11 with i3 = 1, no clock edge needed
    if1.i3_311 = 1'b1;
    {if1.s1_311, if1.s0_311} = 2'b11;
    #1;
    check("comb_y",  8'(if1.y_311), 8'h01);
    check("comb_oh", 8'(if1.sel_oh_311), 8'h08);
`endif

    // Select and data change together at WIDTH 8
    {if8.s1_311, if8.s0_311} = 2'b00;
    step();
    check("simul_pre_y", if8.y_311, 8'h11);
    if8.i2_311 = 8'hA5;
    {if8.s1_311, if8.s0_311} = 2'b10;
    step();
    check("simul_y",  if8.y_311, 8'hA5);
    check("simul_oh", 8'(if8.sel_oh_311), 8'h04);

    // Reset in the middle of operation
    if8.i1_311 = 8'h3C;
    {if8.s1_311, if8.s0_311} = 2'b01;
    step();
    check("mid_pre_y", if8.y_311, 8'h3C);
    rst_n_311 = 1'b0;
    step();
    check("mid_rst_y",  if8.y_311, 8'h00);
    check("mid_rst_oh", 8'(if8.sel_oh_311), 8'h01);
`ifdef MUX4X1_OUT_REG_EN
    rst_n_311 = 1'b1;
    if8.en_311 = 1'b0;
    step();
    check("mid_noen_y",  if8.y_311, 8'h00);
    check("mid_noen_oh", 8'(if8.sel_oh_311), 8'h01);
    if8.en_311 = 1'b1;
    step();
`else
    rst_n_311 = 1'b1;
    step();
`endif
    check("mid_rel_y",  if8.y_311, 8'h3C);
    check("mid_rel_oh", 8'(if8.sel_oh_311), 8'h02);

    // Source 3 at full width
    if8.i3_311 = 8'hC3;
    {if8.s1_311, if8.s0_311} = 2'b11;
    step();
    check("src3_y",  if8.y_311, 8'hC3);
    check("src3_oh", 8'(if8.sel_oh_311), 8'h08);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mux4x1.md
# mux4x1

Parameterised 4-to-1 data selector with a registered output stage, used wherever one of four equal-width sources must be steered onto a single bus under 2-bit select control. Inputs are chosen by the select pair {s1_311, s0_311}. The result is captured on the rising clock edge and exposed together with a one-hot indication of which source is currently driving the output. The block sits between source datapaths and a single downstream consumer, in the same clock domain as both.

## Interface
- WIDTH, 1, bit width of every data input and of y_311
- clk_311  input  1  rising-edge clock; all state updates on this edge
- rst_n_311  input  1  reset, synchronous, active-low
- en_311  input  1  capture enable; 1 = load new selection, 0 = hold
- i0_311  input  WIDTH  data source 0
- i1_311  input  WIDTH  data source 1
- i2_311  input  WIDTH  data source 2
- i3_311  input  WIDTH  data source 3
- s0_311  input  1  select LSB
- s1_311  input  1  select MSB
- y_311  output  WIDTH  selected data
- sel_oh_311  output  4  one-hot source indicator; bit k set = source k driving y_311

## Operation
- Select index = {s1_311, s0_311}:
  - 00 -> i0_311
  - 01 -> i1_311
  - 10 -> i2_311
  - 11 -> i3_311
- sel_oh_311 = 1 << index; exactly one bit set at all times outside reset.
- en_311 = 1: y_311 and sel_oh_311 update from the current inputs and select.
- en_311 = 0: both outputs hold their previous values. Input and select changes are ignored.
- Unknown select bits (X/Z) are never decoded as a valid source. y_311 goes to all-zero and sel_oh_311 to 4'b0000 for that capture.
- No arithmetic is performed. Data passes bit-exact, with no width change.

## Timing
- Reset: rst_n_311 sampled low at a rising edge sets y_311 = 0 and sel_oh_311 = 4'b0001 (source 0 nominal). Reset overrides en_311.
- Latency: 1 cycle. The select and data present at edge N appear on the outputs after edge N.
- Reset deasserted mid-stream: the first capture occurs at the first edge where rst_n_311 is high and en_311 is high.
- Select and data changing on the same edge: the new data of the newly selected source is captured. No mixed or stale result is permitted.
- No handshake. The consumer samples y_311 one cycle after driving the select.

## Configuration
- MUX4X1_OUT_REG_EN defined: output register present, with the 1-cycle latency and hold behaviour described above.
- MUX4X1_OUT_REG_EN undefined: y_311 and sel_oh_311 are combinational from the inputs, with zero latency.
  - en_311 is ignored.
  - While rst_n_311 is low, the outputs are still forced to their reset values (y_311 = 0, sel_oh_311 = 4'b0001).
  - The clock is then unused.

## Structure
- Shared package mux4x1_pkg:
  - 2-bit select type.
  - Constants SEL_I0 = 2'b00, SEL_I1 = 2'b01, SEL_I2 = 2'b10, SEL_I3 = 2'b11.
  - Reset constant for sel_oh (4'b0001).
- Sub-module mux4x1_sel_decode: a combinational 2-to-4 one-hot decoder with X detection. It feeds both the data AND-OR selection and sel_oh_311.

## Test plan
- Reset: hold rst_n_311 = 0 for 2 edges with arbitrary inputs -> y_311 = 0, sel_oh_311 = 0001.
- Sweep, WIDTH = 1, en_311 = 1, i0..i3 = 1,0,1,0:
  - s1s0 = 00 -> y_311 = 1, sel_oh_311 = 0001.
  - 01 -> y_311 = 0, sel_oh_311 = 0010.
  - 10 -> y_311 = 1, sel_oh_311 = 0100.
  - 11 -> y_311 = 0, sel_oh_311 = 1000.
  - Each result appears one edge after its select is applied.
- Hold: select 00 captured (y_311 = 1), then en_311 = 0 with select changed to 01 and i0 toggled -> y_311 stays 1 and sel_oh_311 stays 0001.
- Simultaneous change, WIDTH = 8, i2 = 8'hA5 and select switched 00->10 on the same edge -> next cycle y_311 = 8'hA5, sel_oh_311 = 0100.
- Reset mid-operation: y_311 = 8'h3C, then rst_n_311 = 0 for one edge with en_311 = 1 -> y_311 = 0, sel_oh_311 = 0001; release -> normal capture on the next enabled edge.
- Macro off: rebuild without MUX4X1_OUT_REG_EN and apply select 11 with i3 = 1 -> y_311 = 1 in the same timestep, no clock needed.
